// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hold/flush control for the 5-stage core.
//
// Sources, highest priority first:
//   1. EX-stage jump: redirect the PC and flush if_id/id_ex for FLUSH_CYCLES
//      cycles. The first of these cycles is the jump cycle itself.
//   2. EX-stage multi-cycle op: hold PC, if_id and id_ex until mc_done_i.
//      A watchdog aborts the wait after MC_TIMEOUT cycles.
//   3. ID-stage load-use hazard: insert a single bubble. PC and if_id hold,
//      and id_ex loads a NOP.
//
// Handshake: none. Every control is a zero-latency combinational function
// of the current inputs and the registered FSM state. State advances on the
// rising clk edge. rst is asynchronous and active-high.
//
// Parameters:
//   FLUSH_CYCLES  flush window per jump, including the jump cycle (1..15)
//   MC_TIMEOUT    maximum cycles in MC_WAIT before forced abort (2..255)
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   jump_en_i, jump_addr_i            EX taken branch/jump and its target
//   id_rs1/rs2_addr_i, _ren_i         ID source registers and read enables
//   ex_rd_addr_i, ex_is_load_i        destination register of EX, and load flag
//   mc_start_i, mc_done_i             multi-cycle op issue and completion
//   pc_redirect_o, pc_redirect_addr_o PC redirect request and target
//   hold_pc_o, hold_if_id_o, hold_id_ex_o   stage holds
//   flush_if_id_o, flush_id_ex_o      stage flushes (NOP bubble)
//   mc_timeout_o                      sticky watchdog flag
//   state_o                           FSM state for debug (0 IDLE, 1 FLUSH, 2 MC_WAIT)
//
// Optional build macro PIPE_CTRL_PERF_EN adds the following outputs:
//   stall_cnt_o  cycles with hold_pc_o=1 (wraps at 2^32)
//   flush_cnt_o  cycles with flush_if_id_o=1 (wraps at 2^32)

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_is_load_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  output logic        pc_redirect_o,
  output logic [31:0] pc_redirect_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        mc_timeout_o,
  output logic [1:0]  state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MC_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [7:0]  wait_cnt;
  logic        timeout_flag;

  logic        load_use;
  logic        mc_expire;

  assign state_o = state;

  always_comb begin
    load_use = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
               ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));
    // The watchdog fires in the last permitted wait cycle, and only when
    // the result has not arrived in that same cycle.
    mc_expire = (state == ST_MC_WAIT) && !mc_done_i && (wait_cnt == WAIT_LAST);

    pc_redirect_o      = 1'b0;
    pc_redirect_addr_o = 32'd0;
    hold_pc_o          = 1'b0;
    hold_if_id_o       = 1'b0;
    hold_id_ex_o       = 1'b0;
    flush_if_id_o      = 1'b0;
    flush_id_ex_o      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (jump_en_i) begin
          pc_redirect_o      = 1'b1;
          pc_redirect_addr_o = jump_addr_i;
          flush_if_id_o      = 1'b1;
          flush_id_ex_o      = 1'b1;
        end else if (mc_start_i) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
        end else if (load_use) begin
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Flushed instructions are invalid, so mc_start_i and load-use are ignored here.
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (jump_en_i) begin
          pc_redirect_o      = 1'b1;
          pc_redirect_addr_o = jump_addr_i;
        end
      end
      ST_MC_WAIT: begin
        // Holds drop in the done cycle and in the watchdog-abort cycle.
        if (!mc_done_i && !mc_expire) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
        end
      end
      default: ;
    endcase

    mc_timeout_o = timeout_flag | mc_expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      flush_cnt    <= 4'd0;
      wait_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (jump_en_i) begin
            if (FLUSH_CYCLES > 1) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end else if (mc_start_i) begin
            state    <= ST_MC_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        ST_FLUSH: begin
          if (jump_en_i) begin
            flush_cnt <= FLUSH_INIT;  // a new jump restarts the window
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) state <= ST_IDLE;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done_i) begin
            state <= ST_IDLE;
          end else if (mc_expire) begin
            timeout_flag <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (hold_pc_o)     stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_if_id_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with FLUSH_CYCLES=2 and MC_TIMEOUT=8.
// Inputs are driven 2 time units after each rising edge. The combinational
// controls and the state are sampled 1 unit later, well before the next edge.
// The control vector is {redirect, hold_pc, hold_if_id, hold_id_ex,
// flush_if_id, flush_id_ex, mc_timeout}.

module tb_pipe_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_JUMP   = 7'b1000110;
  localparam logic [6:0] C_FLUSH  = 7'b0000110;
  localparam logic [6:0] C_HOLD   = 7'b0111000;
  localparam logic [6:0] C_BUBBLE = 7'b0110010;
  localparam logic [6:0] C_TMO    = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_ren_i, id_rs2_ren_i, ex_is_load_i;
  logic        mc_start_i, mc_done_i;
  logic        pc_redirect_o;
  logic [31:0] pc_redirect_addr_o;
  logic        hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, mc_timeout_o;
  logic [1:0]  state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];

  pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .pc_redirect_o(pc_redirect_o), .pc_redirect_addr_o(pc_redirect_addr_o),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .mc_timeout_o(mc_timeout_o), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic drive_idle();
    jump_en_i = 1'b0; jump_addr_i = 32'd0;
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    id_rs1_ren_i = 1'b0; id_rs2_ren_i = 1'b0;
    ex_rd_addr_i = 5'd0; ex_is_load_i = 1'b0;
    mc_start_i = 1'b0; mc_done_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1, input logic ren1,
                            input logic [4:0] rs2, input logic ren2);
    ex_is_load_i = 1'b1; ex_rd_addr_i = rd;
    id_rs1_addr_i = rs1; id_rs1_ren_i = ren1;
    id_rs2_addr_i = rs2; id_rs2_ren_i = ren2;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_cycle(input string tag, input logic [6:0] ctl,
                              input logic [31:0] addr, input logic [1:0] st);
    #1;
    check({tag, ".ctl"}, 32'({pc_redirect_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                               flush_if_id_o, flush_id_ex_o, mc_timeout_o}), 32'(ctl));
    check({tag, ".addr"}, pc_redirect_addr_o, addr);
    check({tag, ".state"}, 32'(state_o), 32'(st));
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #2;
    expect_cycle("reset", C_NONE, 32'd0, S_IDLE);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Jump: 2-cycle flush window, then quiet IDLE
    jump_en_i = 1'b1; jump_addr_i = 32'h100;
    expect_cycle("jump.c0", C_JUMP, 32'h100, S_IDLE);
    next_cycle(); drive_idle();
    expect_cycle("jump.c1", C_FLUSH, 32'd0, S_FLUSH);
    next_cycle();
    expect_cycle("jump.c2", C_NONE, 32'd0, S_IDLE);

    // Load-use hazards
    drive_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    expect_cycle("lu.rs2", C_BUBBLE, 32'd0, S_IDLE);
    next_cycle(); drive_idle();
    expect_cycle("lu.after", C_NONE, 32'd0, S_IDLE);
    drive_load(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    expect_cycle("lu.rd0", C_NONE, 32'd0, S_IDLE);
    drive_load(5'd9, 5'd9, 1'b0, 5'd3, 1'b1);
    expect_cycle("lu.ren_off", C_NONE, 32'd0, S_IDLE);
    drive_load(5'd9, 5'd9, 1'b1, 5'd3, 1'b1);
    expect_cycle("lu.rs1", C_BUBBLE, 32'd0, S_IDLE);
    ex_is_load_i = 1'b0;
    expect_cycle("lu.noload", C_NONE, 32'd0, S_IDLE);
    drive_idle();

    // Multi-cycle op: done 4 cycles after start, with a jump mid-wait
    exp_q.push_back(C_HOLD); exp_q.push_back(C_HOLD); exp_q.push_back(C_HOLD);
    exp_q.push_back(C_HOLD); exp_q.push_back(C_NONE);
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      if (i == 0) mc_start_i = 1'b1;
      if (i == 2) begin jump_en_i = 1'b1; jump_addr_i = 32'h200; end
      if (i == 4) mc_done_i = 1'b1;
      expect_cycle($sformatf("mc.c%0d", i), exp_q.pop_front(), 32'd0,
                   (i == 0) ? S_IDLE : S_WAIT);
      next_cycle();
    end
    drive_idle();
    expect_cycle("mc.end", C_NONE, 32'd0, S_IDLE);

    // Jump and mc_start together: jump wins; a second jump restarts the window
    jump_en_i = 1'b1; jump_addr_i = 32'h300; mc_start_i = 1'b1;
    expect_cycle("jm.c0", C_JUMP, 32'h300, S_IDLE);
    next_cycle(); drive_idle();
    jump_en_i = 1'b1; jump_addr_i = 32'h340;
    expect_cycle("jm.c1", C_JUMP, 32'h340, S_FLUSH);
    next_cycle(); drive_idle();
    expect_cycle("jm.c2", C_FLUSH, 32'd0, S_FLUSH);
    next_cycle();
    expect_cycle("jm.c3", C_NONE, 32'd0, S_IDLE);

    // Asynchronous reset between edges while in MC_WAIT
    mc_start_i = 1'b1;
    next_cycle(); drive_idle();
    expect_cycle("ar.wait", C_HOLD, 32'd0, S_WAIT);
    #1 rst = 1'b1;
    expect_cycle("ar.rst", C_NONE, 32'd0, S_IDLE);
    #1 rst = 1'b0;
    next_cycle();
    expect_cycle("ar.after", C_NONE, 32'd0, S_IDLE);
`ifdef PIPE_CTRL_PERF_EN
    check("perf.stall0", stall_cnt_o, 32'd0);
    check("perf.flush0", flush_cnt_o, 32'd0);
    mc_start_i = 1'b1;
    next_cycle(); drive_idle();
    next_cycle();
    next_cycle(); mc_done_i = 1'b1;
    next_cycle(); drive_idle();
    #1;
    check("perf.stall3", stall_cnt_o, 32'd3);
    check("perf.flush3", flush_cnt_o, 32'd0);
`endif

    // Watchdog: 8 hold cycles, then the abort cycle with holds dropped
    mc_start_i = 1'b1;
    expect_cycle("to.c0", C_HOLD, 32'd0, S_IDLE);
    next_cycle(); drive_idle();
    for (int i = 1; i < 8; i++) begin
      expect_cycle($sformatf("to.c%0d", i), C_HOLD, 32'd0, S_WAIT);
      next_cycle();
    end
    expect_cycle("to.c8", C_TMO, 32'd0, S_WAIT);
    next_cycle();
    expect_cycle("to.sticky", C_TMO, 32'd0, S_IDLE);
    drive_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    expect_cycle("to.sticky_lu", C_BUBBLE | C_TMO, 32'd0, S_IDLE);
    next_cycle(); drive_idle();
    expect_cycle("to.still", C_TMO, 32'd0, S_IDLE);
    #1 rst = 1'b1;
    expect_cycle("to.rst", C_NONE, 32'd0, S_IDLE);
    #1 rst = 1'b0;
    next_cycle();
    expect_cycle("to.cleared", C_NONE, 32'd0, S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
